// File: rtl/aes_rcon_seq_if.sv
// Request/status bundle between the key-expansion controller and the round-constant sequencer.
interface aes_rcon_seq_if #(
   parameter int unsigned OUT_W = 32
);
   logic             kld;
   logic [1:0]       key_size;
   logic             dir;
   logic             step;
   logic [OUT_W-1:0] rcon;
   logic             rcon_use;
   logic [5:0]       idx;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output kld, key_size, dir, step,
      input  rcon, rcon_use, idx, busy, done, err
   );

   modport slave (
      input  kld, key_size, dir, step,
      output rcon, rcon_use, idx, busy, done, err
   );
endinterface

// File: rtl/aes_rcon_seq.sv
// AES round-constant sequencer: walks key-expansion word indices forward or backward and
// tracks Rcon with GF(2^8) xtime / inverse-xtime instead of a lookup table.
module aes_rcon_seq #(
   parameter int unsigned OUT_W  = 32,
   parameter bit          INV_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   aes_rcon_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [5:0] r_i, w_i_nxt;
   logic [2:0] r_mod, w_mod_nxt;
   logic [7:0] r_rc, w_rc_nxt;
   logic [3:0] r_nk, w_nk_nxt;
   logic [5:0] r_nw, w_nw_nxt;
   logic       r_dir, w_dir_nxt;
   logic       r_err, w_err_nxt;

   logic       w_ld_ok;
   logic       w_ld_dir;
   logic [3:0] w_ld_nk;
   logic [5:0] w_ld_nw;
   logic [7:0] w_ld_rc;

   function automatic logic [7:0] f_xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] f_ixtime(input logic [7:0] v);
      return v[0] ? (((v ^ 8'h1b) >> 1) | 8'h80) : (v >> 1);
   endfunction

   // Key-size decode; the inverse seed is the last Rcon a forward walk would use.
   always_comb begin
      w_ld_ok = 1'b1;
      w_ld_nk = 4'd4;
      w_ld_nw = 6'd44;
      w_ld_rc = 8'h36;
      unique case (bus.key_size)
         2'b00: begin w_ld_nk = 4'd4; w_ld_nw = 6'd44; w_ld_rc = 8'h36; end
         2'b01: begin w_ld_nk = 4'd6; w_ld_nw = 6'd52; w_ld_rc = 8'h80; end
         2'b10: begin w_ld_nk = 4'd8; w_ld_nw = 6'd60; w_ld_rc = 8'h40; end
         default: w_ld_ok = 1'b0;
      endcase
      w_ld_dir = INV_EN ? bus.dir : 1'b0;
   end

   // Next-state: kld has priority over step; rc only moves when leaving a mod==0 word.
   always_comb begin
      w_state_nxt = r_state;
      w_i_nxt     = r_i;
      w_mod_nxt   = r_mod;
      w_rc_nxt    = r_rc;
      w_nk_nxt    = r_nk;
      w_nw_nxt    = r_nw;
      w_dir_nxt   = r_dir;
      w_err_nxt   = 1'b0;

      if (bus.kld) begin
         if (w_ld_ok) begin
            w_state_nxt = S_RUN;
            w_nk_nxt    = w_ld_nk;
            w_nw_nxt    = w_ld_nw;
            w_dir_nxt   = w_ld_dir;
            if (w_ld_dir) begin
               w_i_nxt   = w_ld_nw - 6'd1;
               w_mod_nxt = 3'd3;
               w_rc_nxt  = w_ld_rc;
            end else begin
               w_i_nxt   = 6'(w_ld_nk);
               w_mod_nxt = 3'd0;
               w_rc_nxt  = 8'h01;
            end
         end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
         end
      end else if (bus.step) begin
         if (r_state == S_RUN) begin
            if (!r_dir) begin
               if (r_i == r_nw - 6'd1) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_i_nxt   = r_i + 6'd1;
                  w_mod_nxt = (r_mod == 3'(r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
                  if (r_mod == 3'd0) w_rc_nxt = f_xtime(r_rc);
               end
            end else if (INV_EN) begin
               if (r_i == 6'(r_nk)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_i_nxt   = r_i - 6'd1;
                  w_mod_nxt = (r_mod == 3'd0) ? 3'(r_nk - 4'd1) : r_mod - 3'd1;
                  if (r_mod == 3'd0) w_rc_nxt = f_ixtime(r_rc);
               end
            end
         end else begin
            w_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_i     <= 6'd0;
         r_mod   <= 3'd0;
         r_rc    <= 8'h01;
         r_nk    <= 4'd4;
         r_nw    <= 6'd44;
         r_dir   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_mod   <= w_mod_nxt;
         r_rc    <= w_rc_nxt;
         r_nk    <= w_nk_nxt;
         r_nw    <= w_nw_nxt;
         r_dir   <= w_dir_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Rcon byte sits in the top byte of the output word.
   assign bus.rcon     = OUT_W'(r_rc) << (OUT_W - 8);
   assign bus.rcon_use = (r_state == S_RUN) && (r_mod == 3'd0);
   assign bus.idx      = r_i;
   assign bus.busy     = (r_state == S_RUN);
   assign bus.done     = (r_state == S_DONE);
   assign bus.err      = r_err;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Randomised and directed checks of aes_rcon_seq against a word-index level Rcon model.
module tb_aes_rcon_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_rcon_seq_if #(.OUT_W(32)) bus32 ();
   aes_rcon_seq_if #(.OUT_W(8))  bus8 ();

   assign bus8.kld      = bus32.kld;
   assign bus8.key_size = bus32.key_size;
   assign bus8.dir      = bus32.dir;
   assign bus8.step     = bus32.step;

   aes_rcon_seq #(.OUT_W(32), .INV_EN(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus32));
   aes_rcon_seq #(.OUT_W(8),  .INV_EN(1'b1)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   int vecs = 0;
   int errs = 0;

   // Model: state 0=idle 1=run 2=done; Rcon derived from word index i and Nk.
   byte unsigned rc_tab [0:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                   8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c};
   int          m_state = 0;
   int          m_i     = 0;
   int          m_nk    = 4;
   int          m_nw    = 44;
   bit          m_dir   = 1'b0;
   bit          m_err   = 1'b0;
   logic [7:0]  m_rc    = 8'h01;

   function automatic logic [7:0] rc_at(input int i, input int nk, input bit dir);
      if (dir) return rc_tab[i / nk - 1];
      else     return rc_tab[(i - 1) / nk];
   endfunction

   function automatic logic [17:0] exp_hdr();
      logic use_b;
      use_b = (m_state == 1) && ((m_i % m_nk) == 0);
      return {(m_state == 1), (m_state == 2), m_err, use_b, 6'(m_i), m_rc};
   endfunction

   function automatic logic [41:0] exp32();
      logic [17:0] h;
      h = exp_hdr();
      return {h, 24'h0};
   endfunction

   function automatic logic [41:0] obs32();
      return {bus32.busy, bus32.done, bus32.err, bus32.rcon_use, bus32.idx, bus32.rcon};
   endfunction

   function automatic logic [17:0] obs8();
      return {bus8.busy, bus8.done, bus8.err, bus8.rcon_use, bus8.idx, bus8.rcon};
   endfunction

   task automatic model_clock(input bit k, input logic [1:0] ks, input bit d, input bit s);
      m_err = 1'b0;
      if (k) begin
         if (ks == 2'b11) begin
            m_state = 0;
            m_err   = 1'b1;
         end else begin
            m_nk    = 4 + 2 * int'(ks);
            m_nw    = 4 * (m_nk + 7);
            m_dir   = d;
            m_state = 1;
            m_i     = d ? m_nw - 1 : m_nk;
            m_rc    = rc_at(m_i, m_nk, m_dir);
         end
      end else if (s) begin
         if (m_state == 1) begin
            if (m_dir ? (m_i == m_nk) : (m_i == m_nw - 1)) begin
               m_state = 2;
            end else begin
               m_i  = m_dir ? m_i - 1 : m_i + 1;
               m_rc = rc_at(m_i, m_nk, m_dir);
            end
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_i     = 0;
      m_rc    = 8'h01;
      m_err   = 1'b0;
   endtask

   task automatic apply(input bit k, input logic [1:0] ks, input bit d, input bit s);
      @(negedge clk);
      bus32.kld      = k;
      bus32.key_size = ks;
      bus32.dir      = d;
      bus32.step     = s;
      @(posedge clk);
      model_clock(k, ks, d, s);
      #1;
      bus32.kld  = 1'b0;
      bus32.step = 1'b0;
   endtask

   task automatic test_reset();
      vecs++;
      if (obs32() !== {4'b0000, 6'd0, 32'h0100_0000}) begin
         $display("FAIL reset_initial: got %h want %h", obs32(), {4'b0000, 6'd0, 32'h0100_0000});
         errs++;
      end
      apply(1'b1, 2'b00, 1'b0, 1'b0);
      for (int n = 0; n < 9; n++) apply(1'b0, 2'b00, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 model_reset();
      vecs++;
      if (obs32() !== {4'b0000, 6'd0, 32'h0100_0000}) begin
         $display("FAIL reset_midwalk: got %h want %h", obs32(), {4'b0000, 6'd0, 32'h0100_0000});
         errs++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b0, 2'b00, 1'b0, 1'b1);
      vecs++;
      if (obs32() !== exp32() || bus32.err !== 1'b1) begin
         $display("FAIL reset_needs_kld: got %h want %h", obs32(), exp32());
         errs++;
      end
   endtask

   task automatic test_aes128_fwd();
      int uses;
      uses = 0;
      apply(1'b1, 2'b00, 1'b0, 1'b0);
      for (int n = 0; n <= 40; n++) begin
         vecs++;
         if (obs32() !== exp32()) begin
            $display("FAIL aes128_fwd step %0d: got %h want %h", n, obs32(), exp32());
            errs++;
         end
         if (bus32.rcon_use) begin
            vecs++;
            if (bus32.rcon[31:24] !== rc_tab[uses] || bus32.idx !== 6'(4 * (uses + 1))) begin
               $display("FAIL aes128_use %0d: got rc %h idx %0d want rc %h idx %0d",
                        uses, bus32.rcon[31:24], bus32.idx, rc_tab[uses], 4 * (uses + 1));
               errs++;
            end
            uses++;
         end
         if (n < 40) apply(1'b0, 2'b00, 1'b0, 1'b1);
      end
      vecs++;
      if (uses != 10 || bus32.done !== 1'b1) begin
         $display("FAIL aes128_total: got uses %0d done %b want uses 10 done 1", uses, bus32.done);
         errs++;
      end
   endtask

   task automatic test_aes192_inv();
      int first_idx, last_idx;
      logic [7:0] first_rc, last_rc;
      first_idx = -1;
      last_idx  = -1;
      first_rc  = 8'h00;
      last_rc   = 8'h00;
      apply(1'b1, 2'b01, 1'b1, 1'b0);
      for (int n = 0; n <= 46; n++) begin
         vecs++;
         if (obs32() !== exp32()) begin
            $display("FAIL aes192_inv step %0d: got %h want %h", n, obs32(), exp32());
            errs++;
         end
         if (bus32.rcon_use) begin
            if (first_idx < 0) begin
               first_idx = int'(bus32.idx);
               first_rc  = bus32.rcon[31:24];
            end
            last_idx = int'(bus32.idx);
            last_rc  = bus32.rcon[31:24];
         end
         if (n < 46) apply(1'b0, 2'b00, 1'b0, 1'b1);
      end
      vecs++;
      if (first_idx != 48 || first_rc !== 8'h80 || last_idx != 6 || last_rc !== 8'h01 ||
          bus32.done !== 1'b1 || bus32.idx !== 6'd6) begin
         $display("FAIL aes192_ends: got first %0d/%h last %0d/%h done %b idx %0d want 48/80 6/01 1 6",
                  first_idx, first_rc, last_idx, last_rc, bus32.done, bus32.idx);
         errs++;
      end
   endtask

   task automatic test_aes256_fwd();
      apply(1'b1, 2'b10, 1'b0, 1'b0);
      for (int n = 0; n <= 52; n++) begin
         vecs++;
         if (obs32() !== exp32()) begin
            $display("FAIL aes256_fwd step %0d: got %h want %h", n, obs32(), exp32());
            errs++;
         end
         if (bus32.idx == 6'd12) begin
            vecs++;
            if (bus32.rcon_use !== 1'b0) begin
               $display("FAIL aes256_i12: got rcon_use %b want 0", bus32.rcon_use);
               errs++;
            end
         end
         if (n < 52) apply(1'b0, 2'b00, 1'b0, 1'b1);
      end
   endtask

   task automatic test_step_after_done();
      apply(1'b0, 2'b00, 1'b0, 1'b1);
      vecs++;
      if (obs32() !== exp32() || bus32.err !== 1'b1 || bus32.idx !== 6'd59) begin
         $display("FAIL step_after_done: got %h want %h", obs32(), exp32());
         errs++;
      end
      apply(1'b0, 2'b00, 1'b0, 1'b0);
      vecs++;
      if (obs32() !== exp32() || bus32.err !== 1'b0) begin
         $display("FAIL err_one_cycle: got %h want %h", obs32(), exp32());
         errs++;
      end
   endtask

   task automatic test_illegal_kld();
      apply(1'b1, 2'b00, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) apply(1'b0, 2'b00, 1'b0, 1'b1);
      apply(1'b1, 2'b11, 1'b0, 1'b0);
      vecs++;
      if (obs32() !== exp32() || bus32.busy !== 1'b0 || bus32.err !== 1'b1) begin
         $display("FAIL illegal_kld: got %h want %h", obs32(), exp32());
         errs++;
      end
   endtask

   task automatic test_kld_step_same();
      apply(1'b1, 2'b01, 1'b0, 1'b0);
      for (int n = 0; n < 7; n++) apply(1'b0, 2'b00, 1'b0, 1'b1);
      apply(1'b1, 2'b00, 1'b1, 1'b1);
      vecs++;
      if (obs32() !== exp32() || bus32.idx !== 6'd43 || bus32.rcon !== 32'h3600_0000 ||
          bus32.err !== 1'b0) begin
         $display("FAIL kld_step_same: got %h want %h", obs32(), exp32());
         errs++;
      end
   endtask

   task automatic test_random();
      bit k, d, s;
      logic [1:0] ks;
      for (int n = 0; n < 600; n++) begin
         k  = ($urandom_range(0, 99) < 4);
         ks = 2'($urandom_range(0, 3));
         d  = 1'($urandom);
         s  = ($urandom_range(0, 99) < 85);
         apply(k, ks, d, s);
         vecs++;
         if (obs32() !== exp32()) begin
            $display("FAIL random32 cyc %0d: got %h want %h", n, obs32(), exp32());
            errs++;
         end
         vecs++;
         if (obs8() !== exp_hdr()) begin
            $display("FAIL random_w8 cyc %0d: got %h want %h", n, obs8(), exp_hdr());
            errs++;
         end
      end
   endtask

   initial begin
      bus32.kld      = 1'b0;
      bus32.key_size = 2'b00;
      bus32.dir      = 1'b0;
      bus32.step     = 1'b0;
      #12;
      test_reset();
      test_aes128_fwd();
      test_aes192_inv();
      test_aes256_fwd();
      test_step_after_done();
      test_illegal_kld();
      test_kld_step_same();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
